// File: rtl/inst_fetcher_if.sv
// Fetch-stage bus bundle: icache lookup/refill,
// memory read channel, redirect and decoder handshake.
interface inst_fetcher_if;
  logic        ic_req_out;
  logic [31:0] ic_addr_out;
  logic        ic_hit_in;
  logic [31:0] ic_inst_in;
  logic        ic_fill_out;
  logic [31:0] ic_fill_addr_out;
  logic [31:0] ic_fill_data_out;
  logic        mem_req_out;
  logic [31:0] mem_addr_out;
  logic        mem_done_in;
  logic [31:0] mem_inst_in;
  logic        flush_in;
  logic [31:0] new_pc_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;

  modport master (
    output ic_req_out, ic_addr_out,
    input  ic_hit_in, ic_inst_in,
    output ic_fill_out, ic_fill_addr_out,
    output ic_fill_data_out,
    output mem_req_out, mem_addr_out,
    input  mem_done_in, mem_inst_in,
    input  flush_in, new_pc_in,
    output out_valid, out_inst, out_pc,
    input  out_ready
  );

  modport slave (
    input  ic_req_out, ic_addr_out,
    output ic_hit_in, ic_inst_in,
    input  ic_fill_out, ic_fill_addr_out,
    input  ic_fill_data_out,
    input  mem_req_out, mem_addr_out,
    output mem_done_in, mem_inst_in,
    output flush_in, new_pc_in,
    input  out_valid, out_inst, out_pc,
    output out_ready
  );
endinterface

// File: rtl/inst_fetcher.sv
// Instruction fetch stage: one icache lookup in flight,
// memory refill on miss, {pc,inst} FIFO to the decoder.
module inst_fetcher #(
  parameter int          QUEUE_BITS = 3,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input logic           clk_in,
  input logic           rst_n_in,
  input logic           rdy_in,
  inst_fetcher_if.master bus
);

  localparam int DEPTH = 1 << QUEUE_BITS;
  localparam int CW    = QUEUE_BITS + 1;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    MEM_WAIT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redir_q, redir_d;
  logic        discard_q, discard_d;
  logic        ic_req_q, ic_req_d;
  logic [31:0] ic_addr_q, ic_addr_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        fill_q, fill_d;
  logic [31:0] fill_addr_q, fill_addr_d;
  logic [31:0] fill_data_q, fill_data_d;

  logic [31:0] fifo_pc_q   [DEPTH];
  logic [31:0] fifo_inst_q [DEPTH];
  logic [QUEUE_BITS-1:0] head_q, head_d;
  logic [QUEUE_BITS-1:0] tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;

  logic        full;
  logic        push;
  logic [31:0] push_inst;
  logic        do_push;
  logic        do_pop;
  logic        flush;

  assign flush = bus.flush_in;
  assign full  = (count_q == CW'(DEPTH));

  // Fetch FSM: issue, resolve hit/miss, track refill and redirect
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    redir_d     = redir_q;
    discard_d   = discard_q;
    ic_req_d    = 1'b0;
    ic_addr_d   = ic_addr_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    fill_d      = 1'b0;
    fill_addr_d = fill_addr_q;
    fill_data_d = fill_data_q;
    push        = 1'b0;
    push_inst   = bus.ic_inst_in;
    unique case (state_q)
      IDLE: begin
        if (flush) begin
          pc_d = bus.new_pc_in;
        end else if (!full) begin
          ic_req_d  = 1'b1;
          ic_addr_d = pc_q;
          state_d   = LOOKUP;
        end
      end
      LOOKUP: begin
        state_d = IDLE;
        if (flush) begin
          pc_d = bus.new_pc_in;
        end else if (bus.ic_hit_in) begin
          push = 1'b1;
          pc_d = pc_q + 32'd4;
        end else begin
          mem_req_d  = 1'b1;
          mem_addr_d = pc_q;
          state_d    = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (bus.mem_done_in) begin
          mem_req_d   = 1'b0;
          fill_d      = 1'b1;
          fill_addr_d = pc_q;
          fill_data_d = bus.mem_inst_in;
          discard_d   = 1'b0;
          state_d     = IDLE;
          if (flush) begin
            pc_d = bus.new_pc_in;
          end else if (discard_q) begin
            pc_d = redir_q;
          end else begin
            push      = 1'b1;
            push_inst = bus.mem_inst_in;
            pc_d      = pc_q + 32'd4;
          end
        end else if (flush) begin
          discard_d = 1'b1;
          redir_d   = bus.new_pc_in;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointer/count update; a redirect empties the queue
  always_comb begin
    do_push = push && !flush;
    do_pop  = (count_q != '0) && bus.out_ready && !flush;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      tail_d  = head_q;
      count_d = '0;
    end else begin
      if (do_push) tail_d = tail_q + 1'b1;
      if (do_pop)  head_d = head_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Control and fetch-state registers, frozen while paused
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      redir_q     <= '0;
      discard_q   <= 1'b0;
      ic_req_q    <= 1'b0;
      ic_addr_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      fill_q      <= 1'b0;
      fill_addr_q <= '0;
      fill_data_q <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      redir_q     <= redir_d;
      discard_q   <= discard_d;
      ic_req_q    <= ic_req_d;
      ic_addr_q   <= ic_addr_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      fill_q      <= fill_d;
      fill_addr_q <= fill_addr_d;
      fill_data_q <= fill_data_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
    end
  end

  // FIFO storage, cleared on reset so head outputs read zero
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc_q[i]   <= '0;
        fifo_inst_q[i] <= '0;
      end
    end else if (rdy_in && do_push) begin
      fifo_pc_q[tail_q]   <= pc_q;
      fifo_inst_q[tail_q] <= push_inst;
    end
  end

  // Pulses are masked while paused so a held register
  // never presents as a repeated request or refill.
  assign bus.ic_req_out       = ic_req_q && rdy_in;
  assign bus.ic_addr_out      = ic_addr_q;
  assign bus.ic_fill_out      = fill_q && rdy_in;
  assign bus.ic_fill_addr_out = fill_addr_q;
  assign bus.ic_fill_data_out = fill_data_q;
  assign bus.mem_req_out      = mem_req_q;
  assign bus.mem_addr_out     = mem_addr_q;
  assign bus.out_valid        = (count_q != '0);
  assign bus.out_inst         = fifo_inst_q[head_q];
  assign bus.out_pc           = fifo_pc_q[head_q];

endmodule
